// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, 2-bit port, 4-bit length, then N data bits MSB first.
// Ports: clock/reset (sync, active-high), clkEN bit strobe, start/port_sel/len/data_in request,
//        SerOut line (idle 1), ready/busy status, done one-cycle frame-end pulse.
module serial_frame_tx #(
  parameter int DATA_W = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clkEN,
  input  logic              start,
  input  logic [1:0]        port_sel,
  input  logic [3:0]        len,
  input  logic [DATA_W-1:0] data_in,
  output logic              SerOut,
  output logic              ready,
  output logic              busy,
  output logic              done
);

  // State names the field whose bit is currently on the line; ARM is
  // "accepted, line still idle, waiting for the first strobe".
  typedef enum logic [2:0] {IDLE, ARM, START, PORT, LEN, DATA} state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;      // bit index shared by PORT and LEN
  logic [3:0]  cnt, cnt_nxt;      // index of data bit currently on the line
  logic        ser_q, ser_nxt;
  logic        done_q, done_nxt;
  logic [1:0]  port_q;
  logic [3:0]  len_q;
  logic [15:0] data_q;            // only bits [14:0] can ever be sent
  logic        accept;

  assign accept = (state == IDLE) && start;

  // State register and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= 2'd0;
      cnt    <= 4'd0;
      ser_q  <= 1'b1;
      done_q <= 1'b0;
      port_q <= 2'd0;
      len_q  <= 4'd0;
      data_q <= 16'd0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      ser_q  <= ser_nxt;
      done_q <= done_nxt;
      if (accept) begin
        port_q <= port_sel;
        len_q  <= len;
        data_q <= {1'b0, data_in[14:0]};
      end
    end
  end

  // Next-state logic; every transition past IDLE is gated by clkEN, so a
  // strobe coinciding with accept is consumed by IDLE and does not advance.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    ser_nxt   = ser_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        ser_nxt = 1'b1;
        if (start) begin
          state_nxt = ARM;
          idx_nxt   = 2'd0;
          cnt_nxt   = 4'd0;
        end
      end
      ARM: begin
        if (clkEN) begin
          state_nxt = START;
          ser_nxt   = 1'b0;
        end
      end
      START: begin
        if (clkEN) begin
          state_nxt = PORT;
          idx_nxt   = 2'd0;
          ser_nxt   = port_q[1];
        end
      end
      PORT: begin
        if (clkEN) begin
          if (idx == 2'd0) begin
            idx_nxt = 2'd1;
            ser_nxt = port_q[0];
          end else begin
            state_nxt = LEN;
            idx_nxt   = 2'd0;
            ser_nxt   = len_q[3];
          end
        end
      end
      LEN: begin
        if (clkEN) begin
          if (idx != 2'd3) begin
            idx_nxt = idx + 2'd1;
            ser_nxt = len_q[2'd2 - idx];
          end else if (len_q != 4'd0) begin
            state_nxt = DATA;
            cnt_nxt   = len_q - 4'd1;
            ser_nxt   = data_q[len_q - 4'd1];
          end else begin
            // Zero-length frame ends straight after the length field
            state_nxt = IDLE;
            ser_nxt   = 1'b1;
            done_nxt  = 1'b1;
          end
        end
      end
      DATA: begin
        if (clkEN) begin
          if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
            ser_nxt = data_q[cnt - 4'd1];
          end else begin
            state_nxt = IDLE;
            ser_nxt   = 1'b1;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        ser_nxt   = 1'b1;
      end
    endcase
  end

  // Outputs: all come straight from registers
  always_comb begin
    SerOut = ser_q;
    done   = done_q;
    ready  = (state == IDLE);
    busy   = (state != IDLE);
  end

endmodule
